// File: rtl/ldpc_iter_sched_if.sv
// Start/stall/syndrome handshake and schedule outputs between the reconciliation
// top level (master) and the LDPC schedule controller (slave).
interface ldpc_iter_sched_if #(
  parameter int LOG2M    = 3,
  parameter int LOG2N    = 4,
  parameter int LOG2ITER = 4
) ();
  logic                start;
  logic                stall;
  logic                syndrome_ok;
  logic [1:0]          state;
  logic [LOG2M-1:0]    row_idx;
  logic [LOG2N-1:0]    col_idx;
  logic [LOG2ITER-1:0] iter_count;
  logic                busy;
  logic                done;
  logic                converged;

  modport master (
    output start, stall, syndrome_ok,
    input  state, row_idx, col_idx, iter_count, busy, done, converged
  );

  modport slave (
    input  start, stall, syndrome_ok,
    output state, row_idx, col_idx, iter_count, busy, done, converged
  );
endinterface

// File: rtl/ldpc_iter_sched.sv
// LDPC decode schedule: alternating check-row / variable-column sweeps for up to MAX_ITER
// iterations. Define EARLY_TERM_EN to end a decode early on syndrome_ok at iteration end.
module ldpc_iter_sched #(
  parameter int M        = 6,
  parameter int LOG2M    = 3,
  parameter int N        = 12,
  parameter int LOG2N    = 4,
  parameter int MAX_ITER = 8,
  parameter int LOG2ITER = 4
) (
  input  logic              clk,
  input  logic              rst,
  ldpc_iter_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, VAR = 2'd2, DONE = 2'd3} state_t;

  localparam logic [LOG2M-1:0]    ROW_LAST  = LOG2M'(M - 1);
  localparam logic [LOG2N-1:0]    COL_LAST  = LOG2N'(N - 1);
  localparam logic [LOG2ITER-1:0] ITER_LAST = LOG2ITER'(MAX_ITER);

  state_t              st;
  logic [LOG2M-1:0]    row;
  logic [LOG2N-1:0]    col;
  logic [LOG2ITER-1:0] iter;
  logic                busy_q, done_q, conv_q;
  logic [LOG2ITER-1:0] iter_nxt;
  logic                early;

  assign iter_nxt = iter + LOG2ITER'(1);

`ifdef EARLY_TERM_EN
  assign early = bus.syndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = bus.syndrome_ok;
  assign early           = 1'b0;
`endif

  // busy/done are registered alongside the state so they change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      row    <= '0;
      col    <= '0;
      iter   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          st     <= CHECK;
          row    <= '0;
          col    <= '0;
          iter   <= '0;
          conv_q <= 1'b0;
          busy_q <= 1'b1;
        end
        CHECK: if (!bus.stall) begin
          if (row == ROW_LAST) begin
            st  <= VAR;
            row <= '0;
            col <= '0;
          end else begin
            row <= row + LOG2M'(1);
          end
        end
        VAR: if (!bus.stall) begin
          if (col == COL_LAST) begin
            col  <= '0;
            iter <= iter_nxt;
            // early exit has priority over the iteration limit
            if (early || iter_nxt == ITER_LAST) begin
              st     <= DONE;
              conv_q <= early;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              st <= CHECK;
            end
          end else begin
            col <= col + LOG2N'(1);
          end
        end
        DONE: begin
          st     <= IDLE;
          done_q <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state      = st;
  assign bus.row_idx    = row;
  assign bus.col_idx    = col;
  assign bus.iter_count = iter;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.converged  = conv_q;
endmodule

// File: tb/tb_ldpc_iter_sched.sv
// Trace-driven bench: each decode is expanded from the sweep rules into a per-cycle
// queue of inputs and expected outputs, then played against the controller.
module tb_ldpc_iter_sched;
  localparam int M = 6, LOG2M = 3, N = 12, LOG2N = 4, MAX_ITER = 8, LOG2ITER = 4;
`ifdef EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldpc_iter_sched_if #(.LOG2M(LOG2M), .LOG2N(LOG2N), .LOG2ITER(LOG2ITER)) bus ();
  ldpc_iter_sched #(.M(M), .LOG2M(LOG2M), .N(N), .LOG2N(LOG2N),
                    .MAX_ITER(MAX_ITER), .LOG2ITER(LOG2ITER))
    dut (.clk(clk), .rst(rst), .bus(bus));

  ldpc_iter_sched_if #(.LOG2M(1), .LOG2N(1), .LOG2ITER(1)) sbus ();
  ldpc_iter_sched #(.M(1), .LOG2M(1), .N(1), .LOG2N(1), .MAX_ITER(1), .LOG2ITER(1))
    dut_s (.clk(clk), .rst(rst), .bus(sbus));

  typedef struct {
    bit         start, stall, syn;
    logic [1:0] st;
    int         row, col, it;
    bit         conv;
  } ent_t;

  ent_t q[$];
  int   checks = 0, failures = 0;
  int   m_iter = 0;
  bit   m_conv = 1'b0;
  bit   g_start_hold = 1'b0;
  int   cut_idx = 0;
  int   ncyc = 0, t0 = 0, lat = 0;

  function automatic bit coin(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic add(input bit start, stall, syn, input logic [1:0] st,
                     input int row, col, it, input bit conv);
    ent_t e;
    e.start = start; e.stall = stall; e.syn = syn; e.st = st;
    e.row = row; e.col = col; e.it = it; e.conv = conv;
    q.push_back(e);
  endtask

  // one schedule position: forced + random stalled copies, then the advancing cycle
  task automatic visit(input logic [1:0] st, input int row, col, it, input int nstall,
                       input bit adv_syn, input bit stall_syn, input int pct);
    int n = nstall;
    if (pct > 0) while (n < nstall + 3 && coin(pct)) n++;
    for (int s = 0; s < n; s++)
      add(g_start_hold | coin(30), 1'b1, stall_syn | coin(50), st, row, col, it, 1'b0);
    add(g_start_hold | coin(30), 1'b0, adv_syn, st, row, col, it, 1'b0);
  endtask

  task automatic build_decode(input int pct, input int syn_iter, input bit rand_syn,
                              input int st_it, input int st_chk, input int st_var);
    bit end_syn = 1'b0;
    bit early   = 1'b0;
    int done_it = 0;
    add(1'b1, coin(50), coin(50), 2'd0, 0, 0, m_iter, m_conv);
    for (int it = 0; it < MAX_ITER; it++) begin
      for (int r = 0; r < M; r++)
        visit(2'd1, r, 0, it, (it == st_it && r == 0) ? st_chk : 0, coin(50), 1'b0, pct);
      for (int c = 0; c < N; c++) begin
        if (it == 3 && c == 5) cut_idx = q.size();
        if (c == N - 1) begin
          end_syn = (it == syn_iter) || (rand_syn && coin(25));
          visit(2'd2, 0, c, it, (it == st_it) ? st_var : 0, end_syn, it == st_it, pct);
        end else begin
          visit(2'd2, 0, c, it, 0, coin(50), 1'b0, pct);
        end
      end
      done_it = it + 1;
      early   = ET && end_syn;
      if (early) break;
    end
    add(g_start_hold | coin(30), coin(50), coin(50), 2'd3, 0, 0, done_it, early);
    m_iter = done_it;
    m_conv = early;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, coin(50), coin(50), 2'd0, 0, 0, m_iter, m_conv);
  endtask

  function automatic logic [15:0] obs();
    return {bus.state, bus.row_idx, bus.col_idx, bus.iter_count,
            bus.busy, bus.done, bus.converged};
  endfunction

  function automatic logic [15:0] sobs();
    return {8'd0, sbus.state, sbus.row_idx, sbus.col_idx, sbus.iter_count,
            sbus.busy, sbus.done, sbus.converged};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // plays n entries (all when n<0) and drops the rest of the trace
  task automatic run(input int n);
    int k = (n < 0) ? q.size() : n;
    for (int i = 0; i < k; i++) begin
      ent_t e = q[i];
      logic [15:0] x;
      @(negedge clk);
      x = {e.st, LOG2M'(e.row), LOG2N'(e.col), LOG2ITER'(e.it),
           (e.st == 2'd1 || e.st == 2'd2), (e.st == 2'd3), e.conv};
      chk($sformatf("cyc%0d", ncyc), obs(), x);
      if (bus.state == 2'd0 && e.start) t0 = ncyc;
      if (bus.done) lat = ncyc - t0 - 1;
      bus.start = e.start; bus.stall = e.stall; bus.syndrome_ok = e.syn;
      ncyc++;
    end
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.syndrome_ok = 1'b0;
    sbus.start = 1'b0; sbus.stall = 1'b0; sbus.syndrome_ok = 1'b0;
    @(negedge clk);
    chk("reset", obs(), 16'd0);
    chk("reset_small", sobs(), 16'd0);
    rst = 1'b0;

    // full-length decode, no stall
    build_decode(0, -1, 1'b0, -1, 0, 0); add_idle(3); run(-1);
    chk("lat_full", 16'(lat), 16'd144);

    // syndrome good at end of third iteration
    build_decode(0, 2, 1'b0, -1, 0, 0); add_idle(2); run(-1);
    chk("lat_early", 16'(lat), ET ? 16'd54 : 16'd144);

    // 5 stalls in CHECK and 3 in VAR (syndrome high while stalled) of iteration 2
    build_decode(0, -1, 1'b0, 1, 5, 3); add_idle(1); run(-1);
    chk("lat_stall", 16'(lat), 16'd152);

    // start held high: back-to-back decodes
    g_start_hold = 1'b1;
    build_decode(0, -1, 1'b0, -1, 0, 0);
    build_decode(0, -1, 1'b0, -1, 0, 0);
    g_start_hold = 1'b0;
    add_idle(2); run(-1);
    chk("lat_b2b", 16'(lat), 16'd144);

    // randomized stalls and syndromes
    repeat (6) begin
      build_decode(20, -1, 1'b1, -1, 0, 0);
      add_idle($urandom_range(0, 3));
      run(-1);
    end

    // reset mid-VAR of iteration 4
    build_decode(0, -1, 1'b0, -1, 0, 0);
    run(cut_idx + 1);
    #2 rst = 1'b1;
    #1 chk("rst_async", obs(), 16'd0);
    @(negedge clk);
    chk("rst_hold", obs(), 16'd0);
    rst = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.syndrome_ok = 1'b0;
    m_iter = 0; m_conv = 1'b0;
    build_decode(0, -1, 1'b0, -1, 0, 0); add_idle(1); run(-1);
    chk("lat_after_rst", 16'(lat), 16'd144);

    // M=N=MAX_ITER=1 instance: CHECK, VAR, DONE, IDLE on consecutive cycles
    @(negedge clk);
    sbus.start = 1'b1;
    @(negedge clk);
    sbus.start = 1'b0;
    chk("small_check", sobs(), {8'd0, 2'd1, 1'b0, 1'b0, 1'b0, 3'b100});
    @(negedge clk);
    chk("small_var", sobs(), {8'd0, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100});
    @(negedge clk);
    chk("small_done", sobs(), {8'd0, 2'd3, 1'b0, 1'b0, 1'b1, 3'b010});
    @(negedge clk);
    chk("small_idle", sobs(), {8'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
